as_lsu: RTL and testbench

- Access-stage load/store unit, directly downstream of the as-stage pipeline register.
- Consumes the registered instruction, ALU result (effective address) and rs2 data.
- Runs a req/gnt/rvalid transaction on the data-memory port and aligns and sign-extends load data.
- Produces the write-back value and a stall request to the pipeline flow controller.

---
 rtl/as_lsu.sv | 177 +++++++++++++++++
 tb/tb_as_lsu.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/as_lsu.sv
// Access-stage load/store unit: decodes loads/stores, runs req/gnt/rvalid on the data port, aligns load data.
// Latency: 3 stall cycles + gnt wait + rvalid wait; write-back value is valid in the DONE cycle.
// Backpressure: stall_req_o holds the upstream pipeline from detection until DONE; bus waits on gnt/rvalid.
module as_lsu #(
  parameter int CPU_WIDTH = 32,
  parameter int TO_WIDTH  = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CPU_WIDTH-1:0] inst_i,
  input  logic [CPU_WIDTH-1:0] alu_res_i,
  input  logic [CPU_WIDTH-1:0] rs2_data_i,
  input  logic                 reg_wr_en_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic [CPU_WIDTH-1:0] mem_addr_o,
  output logic [CPU_WIDTH-1:0] mem_wdata_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [CPU_WIDTH-1:0] mem_rdata_i,
  output logic [CPU_WIDTH-1:0] wb_data_o,
  output logic                 stall_req_o,
  output logic                 misalign_o,
  output logic                 bus_err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // Last counter value spent in WAIT; the timeout fires as this cycle ends.
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

  logic [1:0]           state;
  logic [TO_WIDTH-1:0]  to_cnt;
  logic [CPU_WIDTH-1:0] load_buf;
  logic                 op_load;
  logic [2:0]           op_f3;
  logic [1:0]           op_lane;

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic                 is_load;
  logic                 is_store;
  logic                 sz_h;
  logic                 sz_w;
  logic                 misaligned;
  logic                 go;
  logic [3:0]           be_nxt;
  logic [CPU_WIDTH-1:0] wdata_nxt;
  logic [CPU_WIDTH-1:0] rd_sh;
  logic [CPU_WIDTH-1:0] ld_aligned;

  // Fields not consumed here; rd write enable is acted on by the next stage.
  logic unused_bits;
  assign unused_bits = ^{reg_wr_en_i, inst_i[CPU_WIDTH-1:15], inst_i[11:7]};

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];

  // Decode the instruction into access type, size and alignment.
  always_comb begin
    is_load    = (opcode == OPC_LOAD) &&
                 ((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b101));
    is_store   = (opcode == OPC_STORE) &&
                 ((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010));
    sz_h       = (funct3[1:0] == 2'b01);
    sz_w       = (funct3[1:0] == 2'b10);
    misaligned = (is_load || is_store) &&
                 ((sz_h && alu_res_i[0]) || (sz_w && (alu_res_i[1:0] != 2'b00)));
    go         = (is_load || is_store) && !misaligned;
  end

  // Byte enables and lane-replicated store data for the pending access.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = rs2_data_i;
    if (sz_w) begin
      be_nxt    = 4'b1111;
      wdata_nxt = rs2_data_i;
    end else if (sz_h) begin
      be_nxt    = 4'b0011 << alu_res_i[1:0];
      wdata_nxt = {2{rs2_data_i[15:0]}};
    end else begin
      be_nxt    = 4'b0001 << alu_res_i[1:0];
      wdata_nxt = {4{rs2_data_i[7:0]}};
    end
  end

  // Shift the addressed lane down and sign/zero-extend according to the load type.
  always_comb begin
    rd_sh = mem_rdata_i >> {op_lane, 3'b000};
    case (op_f3)
      3'b000:  ld_aligned = {{(CPU_WIDTH-8){rd_sh[7]}}, rd_sh[7:0]};
      3'b001:  ld_aligned = {{(CPU_WIDTH-16){rd_sh[15]}}, rd_sh[15:0]};
      3'b100:  ld_aligned = {{(CPU_WIDTH-8){1'b0}}, rd_sh[7:0]};
      3'b101:  ld_aligned = {{(CPU_WIDTH-16){1'b0}}, rd_sh[15:0]};
      default: ld_aligned = mem_rdata_i;
    endcase
  end

  // Access FSM with registered bus request fields, timeout counter and load buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      to_cnt      <= '0;
      load_buf    <= '0;
      op_load     <= 1'b0;
      op_f3       <= 3'b000;
      op_lane     <= 2'b00;
      mem_we_o    <= 1'b0;
      mem_be_o    <= 4'b0000;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            state       <= S_REQ;
            mem_we_o    <= is_store;
            mem_be_o    <= be_nxt;
            mem_addr_o  <= {alu_res_i[CPU_WIDTH-1:2], 2'b00};
            mem_wdata_o <= wdata_nxt;
            op_load     <= is_load;
            op_f3       <= funct3;
            op_lane     <= alu_res_i[1:0];
          end else if (misaligned) begin
            misalign_o <= 1'b1;
          end
        end
        S_REQ: begin
          // rvalid in the grant cycle is not a response to this request.
          if (mem_gnt_i) begin
            state       <= S_WAIT;
            to_cnt      <= '0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'b0000;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            state    <= S_DONE;
            load_buf <= op_load ? ld_aligned : '0;
          end else if (to_cnt == TO_LAST) begin
            state     <= S_DONE;
            bus_err_o <= 1'b1;
            load_buf  <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req_o   = (state == S_REQ);
  // Gated by reset so the upstream pipeline is released while reset is held.
  assign stall_req_o = rst_n && (((state == S_IDLE) && go) || (state == S_REQ) || (state == S_WAIT));
  assign wb_data_o   = ((state == S_DONE) && op_load) ? load_buf : alu_res_i;

endmodule

// File: tb/tb_as_lsu.sv
module tb_as_lsu;
  localparam int TOUT = 255;
  localparam logic [6:0]  OP_LD = 7'b0000011;
  localparam logic [6:0]  OP_ST = 7'b0100011;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_i, alu_res_i, rs2_data_i, mem_rdata_i;
  logic        reg_wr_en_i, mem_gnt_i, mem_rvalid_i;
  logic        mem_req_o, mem_we_o, stall_req_o, misalign_o, bus_err_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, wb_data_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  as_lsu #(.CPU_WIDTH(32), .TO_WIDTH(8), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .inst_i(inst_i), .alu_res_i(alu_res_i),
    .rs2_data_i(rs2_data_i), .reg_wr_en_i(reg_wr_en_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wb_data_o(wb_data_o), .stall_req_o(stall_req_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    return {17'd0, f3, 5'd1, opc};
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int n, lane;
    n = nbytes(f3);
    lane = int'(a % 4);
    if (n == 4) return 4'hF;
    if (n == 2) return 4'(3 * (2 ** lane));
    return 4'(2 ** lane);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int n;
    n = nbytes(f3);
    if (n == 1) return (d & 32'hFF) * 32'h01010101;
    if (n == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int n;
    n = nbytes(f3);
    v = rd / (32'd1 << (8 * (a % 4)));
    if (n == 1) begin
      v = v % 256;
      if (f3 == 3'b000 && v >= 128) v = v + 32'hFFFFFF00;
    end else if (n == 2) begin
      v = v % 65536;
      if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  // ---------------- bus driver / observer ----------------
  task automatic idle_cycle();
    @(negedge clk);
    inst_i = NOP; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
  endtask

  task automatic run_access(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] rs2,
                            input logic [31:0] rdata, input int gw, input int rw, input bit no_rv,
                            output logic [3:0] be, output logic [31:0] maddr, output logic [31:0] wdata,
                            output logic we, output int stall_n, output logic [31:0] wb,
                            output logic berr, output bit stable, output bit done_ok);
    int  req_seen, wait_seen;
    bit  granted;
    req_seen = 0; wait_seen = 0; granted = 0;
    be = '0; maddr = '0; wdata = '0; we = 1'b0; wb = '0; berr = 1'b0;
    stall_n = 0; stable = 1; done_ok = 0;
    for (int cyc = 0; cyc < 700 && !done_ok; cyc++) begin
      @(negedge clk);
      inst_i = inst; alu_res_i = addr; rs2_data_i = rs2;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
      if (granted) begin
        wait_seen++;
        if (!no_rv && wait_seen == rw + 1) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
        end
      end else if (mem_req_o) begin
        req_seen++;
        if (req_seen == gw + 1) mem_gnt_i = 1'b1;
        mem_rvalid_i = 1'($urandom_range(0, 1));
      end
      #1;
      if (mem_req_o && !granted) begin
        if (req_seen == 1) begin
          be = mem_be_o; maddr = mem_addr_o; wdata = mem_wdata_o; we = mem_we_o;
        end else if (mem_be_o !== be || mem_addr_o !== maddr || mem_wdata_o !== wdata || mem_we_o !== we) begin
          stable = 0;
        end
      end
      if (granted && !stall_req_o) begin
        done_ok = 1; wb = wb_data_o; berr = bus_err_o;
      end else if (stall_req_o) begin
        stall_n++;
      end
      if (mem_gnt_i) granted = 1;
    end
    idle_cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; inst_i = mk(OP_LD, 3'b010); alu_res_i = 32'h1234_5678; rs2_data_i = $urandom;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = $urandom; reg_wr_en_i = 1'b1;
    #2;
    checks++; if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || mem_be_o !== 4'b0) begin
      errors++; $display("FAIL reset_bus req=%b we=%b be=%b expected 0/0/0000", mem_req_o, mem_we_o, mem_be_o); end
    checks++; if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin
      errors++; $display("FAIL reset_addr addr=%h wdata=%h expected 0", mem_addr_o, mem_wdata_o); end
    checks++; if (stall_req_o !== 1'b0 || misalign_o !== 1'b0 || bus_err_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags stall=%b mis=%b berr=%b expected 0", stall_req_o, misalign_o, bus_err_o); end
    checks++; if (wb_data_o !== 32'h1234_5678) begin
      errors++; $display("FAIL reset_wb got=%h expected=%h", wb_data_o, 32'h1234_5678); end
    repeat (2) @(negedge clk);
    inst_i = NOP;
    rst_n = 1'b1;
    idle_cycle();
  endtask

  task automatic test_lw_basic();
    logic [3:0] be; logic [31:0] a, wd, wb; logic we, berr; int sn; bit st, ok;
    run_access(mk(OP_LD, 3'b010), 32'h100, 32'h0, 32'hDEADBEEF, 1, 1, 0, be, a, wd, we, sn, wb, berr, st, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lw_done no DONE within budget"); end
    checks++; if (be !== 4'b1111 || a !== 32'h100 || we !== 1'b0) begin
      errors++; $display("FAIL lw_bus be=%b addr=%h we=%b expected 1111/00000100/0", be, a, we); end
    checks++; if (sn !== 5) begin errors++; $display("FAIL lw_stall cycles=%0d expected=5", sn); end
    checks++; if (wb !== 32'hDEADBEEF || berr !== 1'b0) begin
      errors++; $display("FAIL lw_wb got=%h berr=%b expected DEADBEEF/0", wb, berr); end
    checks++; if (!st) begin errors++; $display("FAIL lw_stable request fields changed while waiting for gnt"); end
    #1;
    checks++; if (stall_req_o !== 1'b0 || mem_req_o !== 1'b0 || wb_data_o !== alu_res_i) begin
      errors++; $display("FAIL lw_after stall=%b req=%b wb=%h expected 0/0/%h", stall_req_o, mem_req_o, wb_data_o, alu_res_i); end
  endtask

  task automatic test_load_align();
    logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b101};
    logic [31:0] ads [3] = '{32'h103, 32'h103, 32'h102};
    logic [31:0] rds [3] = '{32'h80FF_FFFF, 32'h80FF_FFFF, 32'hF00F_1234};
    logic [31:0] exs [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_F00F};
    logic [3:0] be; logic [31:0] a, wd, wb; logic we, berr; int sn; bit st, ok;
    for (int i = 0; i < 3; i++) begin
      run_access(mk(OP_LD, f3s[i]), ads[i], 32'h0, rds[i], 0, 0, 0, be, a, wd, we, sn, wb, berr, st, ok);
      checks++; if (!ok || wb !== exs[i]) begin
        errors++; $display("FAIL load_align[%0d] done=%0d wb=%h expected=%h", i, ok, wb, exs[i]); end
      checks++; if (be !== m_be(f3s[i], ads[i]) || a !== 32'h100) begin
        errors++; $display("FAIL load_be[%0d] be=%b addr=%h expected %b/00000100", i, be, a, m_be(f3s[i], ads[i])); end
    end
  endtask

  task automatic test_stores();
    logic [3:0] be; logic [31:0] a, wd, wb; logic we, berr; int sn; bit st, ok;
    run_access(mk(OP_ST, 3'b001), 32'h202, 32'h0000ABCD, 32'h0, 0, 1, 0, be, a, wd, we, sn, wb, berr, st, ok);
    checks++; if (!ok || we !== 1'b1 || be !== 4'b1100 || wd !== 32'hABCDABCD || a !== 32'h200) begin
      errors++; $display("FAIL sh done=%0d we=%b be=%b wdata=%h addr=%h expected 1/1100/ABCDABCD/00000200", ok, we, be, wd, a); end
    checks++; if (wb !== 32'h202) begin errors++; $display("FAIL sh_wb got=%h expected=00000202", wb); end
    run_access(mk(OP_ST, 3'b000), 32'h201, 32'h55, 32'h0, 2, 0, 0, be, a, wd, we, sn, wb, berr, st, ok);
    checks++; if (!ok || we !== 1'b1 || be !== 4'b0010 || wd !== 32'h55555555) begin
      errors++; $display("FAIL sb done=%0d we=%b be=%b wdata=%h expected 1/0010/55555555", ok, we, be, wd); end
    checks++; if (sn !== 1 + 3 + 1) begin errors++; $display("FAIL sb_stall cycles=%0d expected=5", sn); end
  endtask

  task automatic test_misalign();
    int pulses, stalls, reqs;
    logic [31:0] wb0;
    pulses = 0; stalls = 0; reqs = 0;
    @(negedge clk);
    inst_i = mk(OP_LD, 3'b010); alu_res_i = 32'h101;
    #1;
    wb0 = wb_data_o;
    if (stall_req_o) stalls++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inst_i = NOP; alu_res_i = $urandom;
      #1;
      if (misalign_o) pulses++;
      if (stall_req_o) stalls++;
      if (mem_req_o) reqs++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL misalign_pulse count=%0d expected=1", pulses); end
    checks++; if (stalls !== 0 || reqs !== 0) begin
      errors++; $display("FAIL misalign_nostall stalls=%0d reqs=%0d expected 0/0", stalls, reqs); end
    checks++; if (wb0 !== 32'h101) begin errors++; $display("FAIL misalign_wb got=%h expected=00000101", wb0); end
  endtask

  task automatic test_timeout();
    logic [3:0] be; logic [31:0] a, wd, wb; logic we, berr; int sn; bit st, ok;
    run_access(mk(OP_LD, 3'b010), 32'h300, 32'h0, 32'hFFFF_FFFF, 0, 0, 1, be, a, wd, we, sn, wb, berr, st, ok);
    checks++; if (!ok || berr !== 1'b1 || wb !== 32'h0) begin
      errors++; $display("FAIL timeout done=%0d berr=%b wb=%h expected 1/1/00000000", ok, berr, wb); end
    checks++; if (sn !== 1 + 1 + TOUT) begin errors++; $display("FAIL timeout_stall cycles=%0d expected=%0d", sn, 2 + TOUT); end
    #1;
    checks++; if (bus_err_o !== 1'b0 || stall_req_o !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL timeout_idle berr=%b stall=%b req=%b expected 0/0/0", bus_err_o, stall_req_o, mem_req_o); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] be; logic [31:0] a, wd, wb; logic we, berr; int sn; bit st, ok, reached;
    for (int ph = 0; ph < 2; ph++) begin
      reached = 0;
      for (int cyc = 0; cyc < 20 && !reached; cyc++) begin
        @(negedge clk);
        inst_i = mk(OP_LD, 3'b010); alu_res_i = 32'h400;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        if (mem_req_o && ph == 0 && cyc >= 2) reached = 1;
        else if (ph == 1 && cyc >= 3 && !mem_req_o && stall_req_o) reached = 1;
        else if (mem_req_o && ph == 1) mem_gnt_i = 1'b1;
      end
      #1;
      checks++; if (!reached || stall_req_o !== 1'b1) begin
        errors++; $display("FAIL rstmid_setup[%0d] reached=%0d stall=%b expected 1/1", ph, reached, stall_req_o); end
      rst_n = 1'b0;
      #1;
      checks++; if (mem_req_o !== 1'b0 || stall_req_o !== 1'b0) begin
        errors++; $display("FAIL rstmid[%0d] req=%b stall=%b expected 0/0", ph, mem_req_o, stall_req_o); end
      @(negedge clk);
      inst_i = NOP; rst_n = 1'b1;
      idle_cycle();
    end
    run_access(mk(OP_LD, 3'b010), 32'h404, 32'h0, 32'hCAFE_F00D, 0, 1, 0, be, a, wd, we, sn, wb, berr, st, ok);
    checks++; if (!ok || wb !== 32'hCAFE_F00D || a !== 32'h404) begin
      errors++; $display("FAIL rstmid_after done=%0d wb=%h addr=%h expected 1/CAFEF00D/00000404", ok, wb, a); end
  endtask

  task automatic test_random();
    logic [6:0] opcs [8] = '{OP_LD, OP_LD, OP_LD, OP_LD, OP_LD, OP_ST, OP_ST, OP_ST};
    logic [2:0] f3s  [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001, 3'b010};
    logic [3:0] be; logic [31:0] a, wd, wb, addr, rs2, rd, exp_wb; logic we, berr; int sn; bit st, ok;
    int k, gw, rw, n;
    for (int i = 0; i < 25; i++) begin
      k = $urandom_range(0, 7);
      n = nbytes(f3s[k]);
      addr = {$urandom_range(0, 65535), 2'b00} + 32'(($urandom_range(0, 3) / n) * n);
      rs2 = $urandom; rd = $urandom;
      gw = $urandom_range(0, 3); rw = $urandom_range(0, 3);
      run_access(mk(opcs[k], f3s[k]), addr, rs2, rd, gw, rw, 0, be, a, wd, we, sn, wb, berr, st, ok);
      exp_wb = (opcs[k] == OP_LD) ? m_load(f3s[k], addr, rd) : addr;
      checks++; if (!ok || wb !== exp_wb || berr !== 1'b0) begin
        errors++; $display("FAIL rnd_wb[%0d] done=%0d wb=%h berr=%b expected %h/0", i, ok, wb, berr, exp_wb); end
      checks++; if (be !== m_be(f3s[k], addr) || a !== (addr & 32'hFFFF_FFFC) || we !== (opcs[k] == OP_ST)) begin
        errors++; $display("FAIL rnd_bus[%0d] be=%b addr=%h we=%b expected %b/%h", i, be, a, we, m_be(f3s[k], addr), addr & 32'hFFFF_FFFC); end
      if (opcs[k] == OP_ST) begin
        checks++; if (wd !== m_wdata(f3s[k], rs2)) begin
          errors++; $display("FAIL rnd_wdata[%0d] got=%h expected=%h", i, wd, m_wdata(f3s[k], rs2)); end
      end
      checks++; if (sn !== 3 + gw + rw || !st) begin
        errors++; $display("FAIL rnd_stall[%0d] cycles=%0d stable=%0d expected %0d/1", i, sn, st, 3 + gw + rw); end
    end
  endtask

  initial begin
    test_reset();
    test_lw_basic();
    test_load_align();
    test_stores();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
